// File: rtl/pcf_sample_scheduler.sv
// Round-robin PCF8591 sample scheduler: periodic per-channel read requests, result store, display feed.
// Optional request timeout is compiled in with `define PCF_SCHED_TIMEOUT_EN.
module pcf_sample_scheduler #(
  parameter int SAMPLE_DIV = 50000,
  parameter int TIMEOUT    = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] ch_mask,
  output logic       rd_req,
  output logic [1:0] rd_ch,
  input  logic       rd_ack,
  input  logic       rd_err,
  input  logic [7:0] rd_data,
  input  logic [1:0] disp_sel,
  output logic [7:0] disp_data,
  output logic       sample_valid,
  output logic [1:0] sample_ch,
  output logic [7:0] sample_data,
  output logic [7:0] err_cnt,
  output logic       overrun,
  output logic       busy
);
  localparam int CW = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0] RELOAD = CW'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {IDLE, REQ, NEXT} state_t;

  state_t          state;
  logic [CW-1:0]   tick_cnt;
  logic            tick;
  logic [3:0]      sweep_mask;
  logic [3:0][7:0] ch_data;
  logic [1:0]      first_ch, next_ch;
  logic            first_ok, next_ok;
  logic [7:0]      err_inc;
  logic            to_hit;

  assign tick    = enable && (tick_cnt == '0);
  assign err_inc = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          tick_cnt <= RELOAD;
    else if (!enable || tick_cnt == '0)  tick_cnt <= RELOAD;
    else                                 tick_cnt <= tick_cnt - 1'b1;
  end

  // Descending scan so the lowest qualifying bit wins.
  always_comb begin
    first_ch = '0;
    first_ok = 1'b0;
    next_ch  = '0;
    next_ok  = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (ch_mask[i]) begin
        first_ch = 2'(i);
        first_ok = 1'b1;
      end
      if (sweep_mask[i] && (2'(i) > rd_ch)) begin
        next_ch = 2'(i);
        next_ok = 1'b1;
      end
    end
  end

`ifdef PCF_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;

  assign to_hit = (to_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     to_cnt <= '0;
    else if (state != REQ || rd_ack) to_cnt <= '0;
    else                            to_cnt <= to_cnt + 1'b1;
  end
`else
  // Never fires; the term keeps TIMEOUT referenced when the timeout is compiled out.
  assign to_hit = 1'b0 && (TIMEOUT > 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sweep_mask   <= '0;
      rd_req       <= 1'b0;
      rd_ch        <= '0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_data  <= '0;
      err_cnt      <= '0;
      overrun      <= 1'b0;
      ch_data      <= '0;
    end else begin
      sample_valid <= 1'b0;
      if (!enable)                     overrun <= 1'b0;
      else if (tick && state != IDLE)  overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (tick && first_ok) begin
            sweep_mask <= ch_mask;
            rd_ch      <= first_ch;
            rd_req     <= 1'b1;
            busy       <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (rd_ack) begin
            rd_req <= 1'b0;
            state  <= NEXT;
            if (rd_err) begin
              err_cnt <= err_inc;
            end else begin
              ch_data[rd_ch] <= rd_data;
              sample_ch      <= rd_ch;
              sample_data    <= rd_data;
              sample_valid   <= 1'b1;
            end
          end else if (to_hit) begin
            rd_req  <= 1'b0;
            err_cnt <= err_inc;
            state   <= NEXT;
          end
        end
        NEXT: begin
          // A dropped enable ends the sweep after the in-flight read.
          if (next_ok && enable) begin
            rd_ch  <= next_ch;
            rd_req <= 1'b1;
            state  <= REQ;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) disp_data <= '0;
    else        disp_data <= ch_data[disp_sel];
  end

endmodule

// File: tb/tb_pcf_sample_scheduler.sv
// Randomized scoreboard bench for pcf_sample_scheduler with a behavioural I2C engine model.
module tb_pcf_sample_scheduler;
  localparam int SDIV = 8;
  localparam int TO   = 16;

  logic       clk = 1'b0;
  logic       rst_n, enable;
  logic [3:0] ch_mask;
  logic       rd_req;
  logic [1:0] rd_ch;
  logic       rd_ack, eng_ack, stray_ack;
  logic       rd_err;
  logic [7:0] rd_data;
  logic [1:0] disp_sel;
  logic [7:0] disp_data;
  logic       sample_valid;
  logic [1:0] sample_ch;
  logic [7:0] sample_data;
  logic [7:0] err_cnt;
  logic       overrun, busy;

  assign rd_ack = eng_ack | stray_ack;

  pcf_sample_scheduler #(.SAMPLE_DIV(SDIV), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ch_mask(ch_mask),
    .rd_req(rd_req), .rd_ch(rd_ch), .rd_ack(rd_ack), .rd_err(rd_err), .rd_data(rd_data),
    .disp_sel(disp_sel), .disp_data(disp_data), .sample_valid(sample_valid),
    .sample_ch(sample_ch), .sample_data(sample_data), .err_cnt(err_cnt),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference state: stored bytes, error total, pending samples {ch,data}
  logic [7:0] m_ch [4];
  int         m_err = 0;
  logic [9:0] sbq [$];

  // engine knobs
  bit         eng_on = 1'b0;
  int         dmin = 1, dmax = 1, err_pct = 0, dmode = 0;
  logic [7:0] fixed_val = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int next_set(input logic [3:0] m, input int after);
    for (int i = after + 1; i < 4; i++) if (m[i]) return i;
    return -1;
  endfunction

  function automatic int sat_err();
    return (m_err > 255) ? 255 : m_err;
  endfunction

  // Engine: acks each request after a random delay, records what the scheduler must store.
  initial begin : engine
    int last, d;
    bit e, more;
    logic [7:0] dat;
    eng_ack = 1'b0; rd_err = 1'b0; rd_data = '0;
    forever begin
      @(negedge clk);
      last = -1;
      while (eng_on && rd_req) begin
        chk("req_ch_order", rd_ch, next_set(ch_mask, last));
        last = rd_ch;
        d = $urandom_range(dmax, dmin);
        repeat (d - 1) @(negedge clk);
        e = ($urandom_range(99) < err_pct);
        case (dmode)
          1:       dat = 8'h10 + 8'(last);
          2:       dat = fixed_val;
          default: dat = 8'($urandom_range(255));
        endcase
        eng_ack = 1'b1; rd_err = e; rd_data = dat;
        if (e) m_err++;
        else begin
          m_ch[last] = dat;
          sbq.push_back({2'(last), dat});
        end
        @(negedge clk);
        eng_ack = 1'b0; rd_err = 1'b0;
        chk("req_gap_low", rd_req, 0);
        more = enable && (next_set(ch_mask, last) >= 0);
        @(negedge clk);
        chk("req_after_gap", rd_req, more);
      end
    end
  end

  // Monitor: every stored sample must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && sample_valid) begin
      if (sbq.size() == 0) chk("unexpected_sample", 1, 0);
      else begin
        logic [9:0] x;
        x = sbq.pop_front();
        chk("sample_ch", sample_ch, x[9:8]);
        chk("sample_data", sample_data, x[7:0]);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic cycle(); @(posedge clk); #2; endtask

  task automatic stop_sweeps();
    int n;
    enable = 1'b0;
    n = 0;
    while (busy && n < 300) begin cycle(); n++; end
    chk("busy_clears", busy, 0);
    repeat (3) cycle();
  endtask

  task automatic check_disp();
    for (int s = 0; s < 4; s++) begin
      disp_sel = 2'(s);
      cycle(); cycle();
      chk($sformatf("disp_ch%0d", s), disp_data, m_ch[s]);
    end
  endtask

  task automatic set_eng(input int lo, input int hi, input int ep, input int mode);
    dmin = lo; dmax = hi; err_pct = ep; dmode = mode;
  endtask

  initial begin : stim
    int n;
    for (int i = 0; i < 4; i++) m_ch[i] = '0;
    rst_n = 1'b0; enable = 1'b0; ch_mask = '0; disp_sel = '0; stray_ack = 1'b0;
    repeat (3) cycle();
    chk("rst_rd_req", rd_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_disp", disp_data, 0);
    chk("rst_sample_valid", sample_valid, 0);
    chk("rst_sample", {sample_ch, sample_data}, 0);
    rst_n = 1'b1;
    cycle();

    // ch_mask 1010 with random data; also times the first tick from enable rising
    eng_on = 1'b1;
    set_eng(1, 4, 0, 0);
    ch_mask = 4'b1010;
    enable  = 1'b1;
    n = 0;
    while (!rd_req && n < 40) begin cycle(); n++; end
    chk("first_req_latency", n, SDIV);
    repeat (200) cycle();
    stop_sweeps();
    check_disp();

    // all channels, ack after 3 cycles with 0x10+ch
    set_eng(3, 3, 0, 1);
    ch_mask = 4'b1111;
    enable  = 1'b1;
    repeat (100) cycle();
    stop_sweeps();
    disp_sel = 2'd2;
    cycle(); cycle();
    chk("disp_ch2_0x12", disp_data, 8'h12);
    check_disp();

    // good read of 0x55 on ch1, then failing reads leave it intact
    fixed_val = 8'h55;
    set_eng(2, 2, 0, 2);
    ch_mask = 4'b0010;
    enable  = 1'b1;
    repeat (12) cycle();
    stop_sweeps();
    n = m_err;
    set_eng(2, 2, 100, 0);
    enable = 1'b1;
    repeat (12) cycle();
    stop_sweeps();
    chk("one_error_seen", m_err - n, 1);
    chk("err_cnt_inc", err_cnt, sat_err());
    disp_sel = 2'd1;
    cycle(); cycle();
    chk("ch1_kept_0x55", disp_data, 8'h55);

    // drive past saturation
    set_eng(1, 1, 100, 0);
    ch_mask = 4'b1111;
    enable  = 1'b1;
    n = 0;
    while (m_err < 310 && n < 4000) begin cycle(); n++; end
    stop_sweeps();
    chk("err_saturates", err_cnt, 255);

    // short single-channel sweeps never overrun
    set_eng(1, 3, 20, 0);
    ch_mask = 4'b0001;
    enable  = 1'b1;
    repeat (100) cycle();
    chk("no_overrun", overrun, 0);
    stop_sweeps();

    // engine stalls beyond a tick period
    set_eng(20, 25, 0, 0);
    ch_mask = 4'b0011;
    enable  = 1'b1;
    repeat (100) cycle();
    chk("overrun_set", overrun, 1);
    stop_sweeps();
    chk("overrun_cleared", overrun, 0);

    // random masks, delays and errors
    for (int p = 0; p < 6; p++) begin
      set_eng(1, 6, 25, 0);
      ch_mask = 4'($urandom_range(15, 1));
      enable  = 1'b1;
      repeat (150) cycle();
      stop_sweeps();
      check_disp();
      chk("err_cnt_model", err_cnt, sat_err());
    end

    // enable drops while channel 2 is pending
    set_eng(5, 5, 0, 0);
    ch_mask = 4'b1111;
    enable  = 1'b1;
    n = 0;
    while (!(rd_req && rd_ch == 2'd2) && n < 200) begin cycle(); n++; end
    chk("ch2_req_seen", rd_req && rd_ch == 2'd2, 1);
    enable = 1'b0;
    n = 0;
    while (busy && n < 50) begin cycle(); n++; end
    chk("busy_after_drop", busy, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (rd_req) n++;
      cycle();
    end
    chk("no_req_after_drop", n, 0);
    check_disp();

`ifdef PCF_SCHED_TIMEOUT_EN
    // engine silent: each request times out into an error
    eng_on  = 1'b0;
    ch_mask = 4'b0011;
    enable  = 1'b1;
    n = 0;
    while (!rd_req && n < 40) begin cycle(); n++; end
    n = 0;
    while (rd_req && n < 40) begin cycle(); n++; end
    chk("timeout_len_ch0", n, TO);
    m_err++;
    chk("timeout_err", err_cnt, sat_err());
    stray_ack = 1'b1;
    cycle();
    stray_ack = 1'b0;
    chk("next_ch_req", {rd_req, rd_ch}, {1'b1, 2'd1});
    n = 0;
    while (rd_req && n < 40) begin cycle(); n++; end
    enable = 1'b0;
    chk("timeout_len_ch1", n, TO - 1);
    m_err++;
    chk("stray_ack_ignored", err_cnt, sat_err());
    stop_sweeps();
`endif

    chk("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
